// File: rtl/sudoku_entry_ctrl_if.sv
// Button, solver and board-RAM port bundle for the Sudoku entry sequencer.
// The slave side is the sequencer; the master side drives buttons/solver status.
interface sudoku_entry_ctrl_if #(
  parameter int CW = 4,
  parameter int VW = 4
);
  logic          Prev;
  logic          Next;
  logic          Enter;
  logic          Start;
  logic          Ack;
  logic [VW-1:0] InputValue;
  logic          Solver_Done;
  logic          Solver_Fail;
  logic          Solver_Start;
  logic          Grant_Solver;
  logic          Mem_Wr;
  logic [VW-1:0] Mem_WData;
  logic          Mem_WFixed;
  logic [CW-1:0] Row;
  logic [CW-1:0] Col;
  logic          Clear;
  logic          Edit;
  logic          Solving;
  logic          Disp;
  logic          Fail;

  modport master (
    output Prev, Next, Enter, Start, Ack, InputValue,
    output Solver_Done, Solver_Fail,
    input  Solver_Start, Grant_Solver,
    input  Mem_Wr, Mem_WData, Mem_WFixed,
    input  Row, Col,
    input  Clear, Edit, Solving, Disp, Fail
  );

  modport slave (
    input  Prev, Next, Enter, Start, Ack, InputValue,
    input  Solver_Done, Solver_Fail,
    output Solver_Start, Grant_Solver,
    output Mem_Wr, Mem_WData, Mem_WFixed,
    output Row, Col,
    output Clear, Edit, Solving, Disp, Fail
  );
endinterface

// File: rtl/sudoku_entry_ctrl.sv
// Sudoku board sequencer: RAM clear sweep, cursor entry UI,
// solver hand-off and result tracking; owns the board-RAM port select.
module sudoku_entry_ctrl #(
  parameter int N  = 9,
  parameter int CW = 4,
  parameter int VW = 4
) (
  input logic              Clk,
  input logic              Reset_n,
  sudoku_entry_ctrl_if.slave bus
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [VW-1:0] VMAX = VW'(N);

  typedef enum logic [4:0] {
    S_CLEAR = 5'b00001,
    S_EDIT  = 5'b00010,
    S_SOLVE = 5'b00100,
    S_DISP  = 5'b01000,
    S_FAIL  = 5'b10000
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          wr_q, wr_d;
  logic          fixed_q, fixed_d;
  logic          start_q, start_d;
  logic [VW-1:0] wdata_q, wdata_d;

  logic [CW-1:0] nx_row, nx_col;
  logic [CW-1:0] pv_row, pv_col;

  // row-major cursor neighbours with wrap at both ends of the board
  always_comb begin
    nx_row = row_q;
    nx_col = col_q + 1'b1;
    if (col_q == LAST) begin
      nx_col = '0;
      nx_row = (row_q == LAST) ? '0 : row_q + 1'b1;
    end
    pv_row = row_q;
    pv_col = col_q - 1'b1;
    if (col_q == '0) begin
      pv_col = LAST;
      pv_row = (row_q == '0) ? LAST : row_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_d    = 1'b0;
    start_d = 1'b0;
    wdata_d = wdata_q;
    fixed_d = fixed_q;
    unique case (state_q)
      S_CLEAR: begin
        row_d = nx_row;
        col_d = nx_col;
        if (row_q == LAST && col_q == LAST)
          state_d = S_EDIT;
      end
      S_EDIT: begin
        if (bus.Start) begin
          start_d = 1'b1;
          state_d = S_SOLVE;
        end else if (bus.Enter) begin
          if (bus.InputValue <= VMAX) begin
            wr_d    = 1'b1;
            wdata_d = bus.InputValue;
            fixed_d = |bus.InputValue;
          end
        end else if (bus.Next) begin
          row_d = nx_row;
          col_d = nx_col;
        end else if (bus.Prev) begin
          row_d = pv_row;
          col_d = pv_col;
        end
      end
      S_SOLVE: begin
        if (bus.Solver_Fail)
          state_d = S_FAIL;
        else if (bus.Solver_Done)
          state_d = S_DISP;
      end
      S_DISP: begin
        if (bus.Ack) begin
          state_d = S_CLEAR;
          row_d   = '0;
          col_d   = '0;
        end else if (bus.Next) begin
          row_d = nx_row;
          col_d = nx_col;
        end else if (bus.Prev) begin
          row_d = pv_row;
          col_d = pv_col;
        end
      end
      S_FAIL: begin
        if (bus.Ack)
          state_d = S_EDIT;
      end
      default: begin
        state_d = S_CLEAR;
        row_d   = '0;
        col_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_CLEAR;
      row_q   <= '0;
      col_q   <= '0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      wdata_q <= '0;
      fixed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wr_q    <= wr_d;
      start_q <= start_d;
      wdata_q <= wdata_d;
      fixed_q <= fixed_d;
    end
  end

  // an entry write only ever lands in EDIT, so it cannot meet the grant
  assign bus.Mem_Wr       = (state_q == S_CLEAR) | wr_q;
  assign bus.Mem_WData    = wr_q ? wdata_q : '0;
  assign bus.Mem_WFixed   = wr_q & fixed_q;
  assign bus.Solver_Start = start_q;
  assign bus.Grant_Solver = (state_q == S_SOLVE);
  assign bus.Row          = row_q;
  assign bus.Col          = col_q;
  assign bus.Clear        = (state_q == S_CLEAR);
  assign bus.Edit         = (state_q == S_EDIT);
  assign bus.Solving      = (state_q == S_SOLVE);
  assign bus.Disp         = (state_q == S_DISP);
  assign bus.Fail         = (state_q == S_FAIL);

endmodule

// File: tb/tb_sudoku_entry_ctrl.sv
// Directed bench for sudoku_entry_ctrl: linear-index cell model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_sudoku_entry_ctrl;

  localparam int P  = 1;
  localparam int NX = 2;
  localparam int EN = 4;
  localparam int ST = 8;
  localparam int AK = 16;
  localparam int DN = 32;
  localparam int FL = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  sudoku_entry_ctrl_if #(.CW(4), .VW(4)) bus ();

  sudoku_entry_ctrl #(.N(9), .CW(4), .VW(4)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // model: mode 0 clear, 1 edit, 2 solving, 3 disp, 4 fail; idx = row*9+col
  int m_mode = 0;
  int m_idx = 0;
  int m_pval = 0;
  bit m_pend = 0;
  bit m_start = 0;
  bit m_on = 0;
  bit m_np;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_idx = 0; m_pend = 0; m_start = 0; m_on = 1;
    end else begin
      m_np = 0;
      m_start = 0;
      case (m_mode)
        0: begin
          if (m_idx == 80) begin m_mode = 1; m_idx = 0; end
          else m_idx = m_idx + 1;
        end
        1: begin
          if (bus.Start) begin m_mode = 2; m_start = 1; end
          else if (bus.Enter) begin
            if (int'(bus.InputValue) <= 9) begin
              m_np = 1; m_pval = int'(bus.InputValue);
            end
          end
          else if (bus.Next) m_idx = (m_idx + 1) % 81;
          else if (bus.Prev) m_idx = (m_idx + 80) % 81;
        end
        2: begin
          if (bus.Solver_Fail) m_mode = 4;
          else if (bus.Solver_Done) m_mode = 3;
        end
        3: begin
          if (bus.Ack) begin m_mode = 0; m_idx = 0; end
          else if (bus.Next) m_idx = (m_idx + 1) % 81;
          else if (bus.Prev) m_idx = (m_idx + 80) % 81;
        end
        default: if (bus.Ack) m_mode = 1;
      endcase
      m_pend = m_np;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      logic [4:0] ef, gf;
      bit ew, ok;
      int ed, efx;
      ef = 5'(1 << m_mode);
      gf = {bus.Fail, bus.Disp, bus.Solving, bus.Edit, bus.Clear};
      ew = (m_mode == 0) || m_pend;
      ed = (m_mode == 0) ? 0 : m_pval;
      efx = (m_mode != 0 && m_pval != 0) ? 1 : 0;
      ok = (gf == ef) && (bus.Mem_Wr == ew)
        && (int'(bus.Row) == m_idx / 9) && (int'(bus.Col) == m_idx % 9)
        && (bus.Grant_Solver == (m_mode == 2)) && (bus.Solver_Start == m_start);
      if (ew)
        ok = ok && (int'(bus.Mem_WData) == ed) && (int'(bus.Mem_WFixed) == efx);
      nvec++;
      if (!ok) begin
        nerr++;
        $display("FAIL model t=%0t got st=%b rc=%0d,%0d wr=%b wd=%0d wf=%b ss=%b g=%b req st=%b rc=%0d,%0d wr=%b wd=%0d wf=%0d ss=%b g=%b",
          $time, gf, bus.Row, bus.Col, bus.Mem_Wr, bus.Mem_WData, bus.Mem_WFixed,
          bus.Solver_Start, bus.Grant_Solver, ef, m_idx / 9, m_idx % 9, ew, ed, efx,
          m_start, (m_mode == 2));
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s t=%0t got %0d required %0d", nm, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int m, input int v);
    bus.Prev        = m[0];
    bus.Next        = m[1];
    bus.Enter       = m[2];
    bus.Start       = m[3];
    bus.Ack         = m[4];
    bus.Solver_Done = m[5];
    bus.Solver_Fail = m[6];
    bus.InputValue  = 4'(v);
    tick();
    bus.Prev = 0; bus.Next = 0; bus.Enter = 0; bus.Start = 0;
    bus.Ack = 0; bus.Solver_Done = 0; bus.Solver_Fail = 0;
  endtask

  task automatic sweep(input string nm);
    int n;
    n = 0;
    while (bus.Clear && n < 200) begin
      if (bus.Mem_Wr !== 1'b1 || int'(bus.Row) != n / 9 || int'(bus.Col) != n % 9)
        chk({nm, "_addr"}, int'(bus.Row) * 9 + int'(bus.Col), n);
      n++;
      tick();
    end
    chk({nm, "_len"}, n, 81);
    chk({nm, "_edit"}, int'(bus.Edit), 1);
    chk({nm, "_rc"}, int'(bus.Row) * 16 + int'(bus.Col), 0);
  endtask

  initial begin
    bus.Prev = 0; bus.Next = 0; bus.Enter = 0; bus.Start = 0;
    bus.Ack = 0; bus.Solver_Done = 0; bus.Solver_Fail = 0;
    bus.InputValue = 0;
    rst_n = 0;
    tick();
    tick();
    chk("rst_clear", int'(bus.Clear), 1);
    chk("rst_rc", int'(bus.Row) * 16 + int'(bus.Col), 0);
    chk("rst_grant", int'(bus.Grant_Solver), 0);
    chk("rst_sstart", int'(bus.Solver_Start), 0);
    chk("rst_wdata", int'(bus.Mem_WData), 0);
    chk("rst_wfixed", int'(bus.Mem_WFixed), 0);
    rst_n = 1;
    sweep("sweep0");

    press(P, 0);
    chk("prev_wrap", int'(bus.Row) * 16 + int'(bus.Col), 8 * 16 + 8);
    press(NX, 0);
    chk("next_wrap", int'(bus.Row) * 16 + int'(bus.Col), 0);
    for (int i = 0; i < 9; i++) press(NX, 0);
    chk("next_row", int'(bus.Row) * 16 + int'(bus.Col), 1 * 16 + 0);
    for (int i = 0; i < 12; i++) press(NX, 0);
    chk("at_2_3", int'(bus.Row) * 16 + int'(bus.Col), 2 * 16 + 3);
    press(DN | FL, 0);
    chk("done_in_edit", int'(bus.Edit), 1);

    press(EN, 5);
    chk("wr5_en", int'(bus.Mem_Wr), 1);
    chk("wr5_rc", int'(bus.Row) * 16 + int'(bus.Col), 2 * 16 + 3);
    chk("wr5_data", int'(bus.Mem_WData), 5);
    chk("wr5_fixed", int'(bus.Mem_WFixed), 1);
    tick();
    chk("wr5_single", int'(bus.Mem_Wr), 0);
    press(EN, 0);
    chk("wr0_en", int'(bus.Mem_Wr), 1);
    chk("wr0_fixed", int'(bus.Mem_WFixed), 0);
    tick();
    press(EN, 12);
    chk("wr12_none", int'(bus.Mem_Wr), 0);
    press(EN, 9);
    chk("wr9_en", int'(bus.Mem_Wr), 1);
    press(EN, 7);
    chk("wr7_data", int'(bus.Mem_WData), 7);
    press(NX, 0);
    chk("move_in_wr", int'(bus.Row) * 16 + int'(bus.Col), 2 * 16 + 4);
    chk("move_in_wr_done", int'(bus.Mem_Wr), 0);
    press(NX | P, 0);
    chk("next_over_prev", int'(bus.Col), 5);
    press(EN | NX, 3);
    chk("enter_over_next", int'(bus.Col), 5);
    tick();

    press(ST | EN, 4);
    chk("start_pulse", int'(bus.Solver_Start), 1);
    chk("start_grant", int'(bus.Grant_Solver), 1);
    chk("start_nowr", int'(bus.Mem_Wr), 0);
    tick();
    chk("start_single", int'(bus.Solver_Start), 0);
    press(NX | EN | AK, 6);
    chk("solve_ignore", int'(bus.Solving) * 16 + int'(bus.Col), 16 + 5);
    press(DN, 0);
    chk("done_disp", int'(bus.Disp), 1);
    chk("done_grant", int'(bus.Grant_Solver), 0);
    press(NX, 0);
    chk("disp_next", int'(bus.Col), 6);
    press(EN | ST, 2);
    chk("disp_ignore", int'(bus.Disp) * 2 + int'(bus.Mem_Wr), 2);
    press(P, 0);
    chk("disp_prev", int'(bus.Col), 5);
    press(AK, 0);
    chk("ack_clear_rc", int'(bus.Row) * 16 + int'(bus.Col), 0);
    sweep("sweep1");

    press(NX, 0);
    press(EN, 9);
    chk("pend_wr", int'(bus.Mem_Wr) * 2 + int'(bus.Grant_Solver), 2);
    press(ST, 0);
    chk("pend_then_grant", int'(bus.Mem_Wr) * 2 + int'(bus.Grant_Solver), 1);
    press(DN | FL, 0);
    chk("both_fail", int'(bus.Fail), 1);
    chk("fail_grant", int'(bus.Grant_Solver), 0);
    press(NX | EN | ST, 1);
    chk("fail_ignore", int'(bus.Fail) * 16 + int'(bus.Col), 16 + 1);
    press(AK, 0);
    chk("fail_ack_edit", int'(bus.Edit), 1);
    chk("fail_ack_rc", int'(bus.Row) * 16 + int'(bus.Col), 1);
    chk("fail_ack_nowr", int'(bus.Mem_Wr), 0);

    press(ST, 0);
    chk("solve2", int'(bus.Solving), 1);
    rst_n = 0;
    tick();
    chk("rst_solve_grant", int'(bus.Grant_Solver), 0);
    chk("rst_solve_clear", int'(bus.Clear), 1);
    chk("rst_solve_rc", int'(bus.Row) * 16 + int'(bus.Col), 0);
    rst_n = 1;
    sweep("sweep2");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
